// File: rtl/switch_seq_pkg.sv
// Shared types and byte encoding for the switch sequencer.
// Command byte layout: {2-bit command code, 6-bit payload}.
package switch_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        StIdle,
        StCfgW,
        StCfgR,
        StStart,
        StWait,
        StResp
    } seq_state_e;

    // 2-bit command codes in the top bits of every tile command byte
    typedef enum logic [1:0] {
        CmdCfgWeight = 2'b00,
        CmdCfgRoute  = 2'b01,
        CmdStart     = 2'b10,
        CmdEnd       = 2'b11
    } cmd_code_e;

    localparam logic [7:0] EndByte = 8'hC0;

    // Job fields latched on acceptance
    typedef struct packed {
        logic [3:0] weight;
        logic       route;
        logic       offset;
        logic       op;
        logic [5:0] operand;
    } job_t;

    function automatic logic [7:0] cmd_byte(cmd_code_e code, logic [5:0] payload);
        return {code, payload};
    endfunction

endpackage

// File: rtl/switch_sequencer.sv
// Switch sequencer: turns host jobs into a WEIGHT / [ROUTE] / START command
// byte sequence for a tile switch and, for compute jobs, samples the tile
// result RESULT_WAIT cycles after the START byte.
// Optional feature: define SWITCH_SEQ_JOB_CNT_EN to add the 8-bit job_count output.
module switch_sequencer
    import switch_seq_pkg::*;
#(
    parameter int unsigned RESULT_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [3:0] job_weight,
    input  logic       job_route,
    input  logic       job_offset,
    input  logic       job_op,
    input  logic [5:0] job_operand,
    output logic [7:0] tile_cmd_out,
    input  logic [7:0] tile_rsp_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data
`ifdef SWITCH_SEQ_JOB_CNT_EN
    ,
    output logic [7:0] job_count
`endif
);

    localparam logic [3:0] WaitLoad = 4'(RESULT_WAIT - 1);

    seq_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    job_t       job_q, job_d;
    logic [7:0] res_data_q;
    logic       capture;
    logic       res_done;
    logic       route_done;

    // State, counter, latched job and captured result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            job_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            job_q   <= job_d;
            if (capture) begin
                res_data_q <= tile_rsp_in;
            end
        end
    end

    // Next-state logic and per-state outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        job_d        = job_q;
        job_ready    = 1'b0;
        res_valid    = 1'b0;
        tile_cmd_out = EndByte;
        capture      = 1'b0;
        res_done     = 1'b0;
        route_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    job_d.weight  = job_weight;
                    job_d.route   = job_route;
                    job_d.offset  = job_offset;
                    job_d.op      = job_op;
                    job_d.operand = job_operand;
                    state_d       = StCfgW;
                end
            end
            StCfgW: begin
                tile_cmd_out = cmd_byte(CmdCfgWeight, {2'b00, job_q.weight});
                state_d      = job_q.route ? StCfgR : StStart;
            end
            StCfgR: begin
                tile_cmd_out = cmd_byte(CmdCfgRoute, {1'b0, job_q.offset, 3'b000, job_q.op});
                state_d      = StStart;
            end
            StStart: begin
                tile_cmd_out = cmd_byte(CmdStart, job_q.operand);
                if (job_q.route) begin
                    route_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d   = WaitLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_data = res_data_q;

`ifdef SWITCH_SEQ_JOB_CNT_EN
    logic [7:0] job_count_q;

    // Completed-job counter: result transfers plus route jobs leaving START
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_count_q <= '0;
        end else if (res_done || route_done) begin
            job_count_q <= job_count_q + 8'd1;
        end
    end

    assign job_count = job_count_q;
`else
    logic unused_done;
    assign unused_done = res_done ^ route_done;
`endif

endmodule

// File: tb/tb_switch_sequencer.sv
// Self-checking bench for switch_sequencer. A queue-based schedule model
// predicts the command byte stream and result handshake every cycle.
// Define SWITCH_SEQ_JOB_CNT_EN to also exercise job_count.
module tb_switch_sequencer;

    localparam int unsigned RW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [3:0] job_weight = '0;
    logic       job_route = 1'b0;
    logic       job_offset = 1'b0;
    logic       job_op = 1'b0;
    logic [5:0] job_operand = '0;
    logic [7:0] tile_cmd_out;
    logic [7:0] tile_rsp_in = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
`ifdef SWITCH_SEQ_JOB_CNT_EN
    logic [7:0] job_count;
`endif

    switch_sequencer #(.RESULT_WAIT(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_weight  (job_weight),
        .job_route   (job_route),
        .job_offset  (job_offset),
        .job_op      (job_op),
        .job_operand (job_operand),
        .tile_cmd_out(tile_cmd_out),
        .tile_rsp_in (tile_rsp_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef SWITCH_SEQ_JOB_CNT_EN
        ,
        .job_count   (job_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a schedule of upcoming command bytes, one per cycle.
    typedef struct {
        logic [7:0] b;
        bit         cap;   // consuming this slot samples tile_rsp_in as the result
        bit         rdone; // consuming this slot completes a route job
    } slot_t;

    slot_t      sched[$];
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [7:0] m_cnt   = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_cnt   = 8'h00;
        end else begin
            bit    accept;
            slot_t s;
            accept = (sched.size() == 0) && !m_valid && (job_valid === 1'b1);
            if (sched.size() > 0) begin
                s = sched.pop_front();
                if (s.cap) begin
                    m_data  = tile_rsp_in;
                    m_valid = 1'b1;
                end
                if (s.rdone) m_cnt = m_cnt + 8'd1;
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
                m_cnt   = m_cnt + 8'd1;
            end
            if (accept) begin
                sched.push_back('{b: {4'h0, job_weight}, cap: 1'b0, rdone: 1'b0});
                if (job_route) begin
                    sched.push_back('{b: 8'h40 + 8'(job_offset) * 8'd16 + 8'(job_op),
                                      cap: 1'b0, rdone: 1'b0});
                    sched.push_back('{b: 8'h80 + 8'(job_operand), cap: 1'b0, rdone: 1'b1});
                end else begin
                    sched.push_back('{b: 8'h80 + 8'(job_operand), cap: 1'b0, rdone: 1'b0});
                    for (int i = 0; i < int'(RW); i++)
                        sched.push_back('{b: 8'hC0, cap: (i == int'(RW) - 1), rdone: 1'b0});
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [7:0] exp_cmd;
        exp_cmd = (sched.size() > 0) ? sched[0].b : 8'hC0;
        check8("cmd", tile_cmd_out, exp_cmd);
        check8("job_ready", {7'd0, job_ready}, {7'd0, (sched.size() == 0) && !m_valid});
        check8("res_valid", {7'd0, res_valid}, {7'd0, m_valid});
        check8("res_data", res_data, m_data);
`ifdef SWITCH_SEQ_JOB_CNT_EN
        check8("job_count", job_count, m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] w, input logic r, input logic off, input logic op,
                         input logic [5:0] operand);
        job_valid   = 1'b1;
        job_weight  = w;
        job_route   = r;
        job_offset  = off;
        job_op      = op;
        job_operand = operand;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (res_valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check8(name, {7'd0, res_valid}, 8'd1);
    endtask

    logic [7:0] held;
    int         xfers;
    int         guard;

    initial begin
        repeat (2) step();
        check8("reset_cmd", tile_cmd_out, 8'hC0);
        check8("reset_res_valid", {7'd0, res_valid}, 8'd0);
        check8("reset_res_data", res_data, 8'h00);
        rst = 1'b0;
        step();
        check8("ready_after_reset", {7'd0, job_ready}, 8'd1);

        // Compute job: weight 5, op 0, operand 03, result 0x11
        tile_rsp_in = 8'h11;
        offer(4'd5, 1'b0, 1'b0, 1'b0, 6'h03);
        step();                         // cycle 1
        job_valid = 1'b0;
        check8("c_weight", tile_cmd_out, 8'h05);
        check8("c_busy", {7'd0, job_ready}, 8'd0);
        step();                         // cycle 2
        check8("c_start", tile_cmd_out, 8'h83);
        step();                         // cycle 3
        check8("c_end", tile_cmd_out, 8'hC0);
        check8("c_no_valid3", {7'd0, res_valid}, 8'd0);
        step();                         // cycle 4
        check8("c_no_valid4", {7'd0, res_valid}, 8'd0);
        step();                         // cycle 5
        check8("c_valid5", {7'd0, res_valid}, 8'd1);
        check8("c_data", res_data, 8'h11);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check8("c_valid_drop", {7'd0, res_valid}, 8'd0);
        check8("c_ready_back", {7'd0, job_ready}, 8'd1);

        // Route job: weight A, offset 1, op 1, operand 2A
        offer(4'hA, 1'b1, 1'b1, 1'b1, 6'h2A);
        step();
        job_valid = 1'b0;
        check8("r_weight", tile_cmd_out, 8'h0A);
        step();
        check8("r_route", tile_cmd_out, 8'h51);
        step();
        check8("r_start", tile_cmd_out, 8'hAA);
        step();
        check8("r_end", tile_cmd_out, 8'hC0);
        check8("r_ready4", {7'd0, job_ready}, 8'd1);
        check8("r_no_valid", {7'd0, res_valid}, 8'd0);

        // Result held with res_ready low for 10 cycles
        tile_rsp_in = 8'h5C;
        offer(4'd3, 1'b0, 1'b0, 1'b1, 6'h11);
        step();
        job_valid = 1'b0;
        tile_rsp_in = 8'h00;
        wait_valid("h_valid");
        held = res_data;
        for (int i = 0; i < 10; i++) begin
            tile_rsp_in = 8'($urandom);
            check8("h_valid_stable", {7'd0, res_valid}, 8'd1);
            check8("h_data_stable", res_data, held);
            check8("h_not_ready", {7'd0, job_ready}, 8'd0);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check8("h_idle", {7'd0, job_ready}, 8'd1);

        // Back-to-back: second WEIGHT two cycles after first transfer
        offer(4'd7, 1'b0, 1'b0, 1'b0, 6'h01);
        res_ready = 1'b1;
        step();
        wait_valid("b_valid");
        step();
        step();
        check8("b_second_weight", tile_cmd_out, 8'h07);
        job_valid = 1'b0;
        res_ready = 1'b0;

        // Reset in the middle of WAIT
        wait_valid("m_drain");
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        offer(4'd9, 1'b0, 1'b0, 1'b0, 6'h3F);
        step();
        job_valid = 1'b0;
        step();
        step();                         // WAIT
        rst = 1'b1;
        #1;
        check8("m_rst_cmd", tile_cmd_out, 8'hC0);
        check8("m_rst_valid", {7'd0, res_valid}, 8'd0);
        step();
        rst = 1'b0;
        step();
        check8("m_ready", {7'd0, job_ready}, 8'd1);
        check8("m_no_result", {7'd0, res_valid}, 8'd0);

`ifdef SWITCH_SEQ_JOB_CNT_EN
        // 256 compute jobs bring job_count back to its starting value
        held = job_count;
        offer(4'd1, 1'b0, 1'b0, 1'b0, 6'h02);
        res_ready = 1'b1;
        xfers = 0;
        guard = 0;
        while (xfers < 256 && guard < 4000) begin
            if (res_valid === 1'b1) xfers++;
            step();
            guard++;
        end
        job_valid = 1'b0;
        res_ready = 1'b0;
        check8("cnt_wrap", job_count, held);
        wait_valid("cnt_drain");
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            job_valid   = ($urandom_range(0, 2) != 0);
            job_weight  = 4'($urandom);
            job_route   = 1'($urandom);
            job_offset  = 1'($urandom);
            job_op      = 1'($urandom);
            job_operand = 6'($urandom);
            res_ready   = 1'($urandom);
            tile_rsp_in = 8'($urandom);
            rst         = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        job_valid = 1'b0;
        res_ready = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
